phat_chuoi_1011: RTL and testbench



---
 rtl/phat_chuoi_1011.sv | 159 +++++++++++++++
 tb/tb_phat_chuoi_1011.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phat_chuoi_1011.sv
// -----------------------------------------------------------------------------
// phat_chuoi_1011 - serial stimulus transmitter for the 1011 detector path.
//
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// MSB-first, one bit per clock, on a registered single-bit line. GAP_CYCLES
// zero cycles follow every word. A reference counter tracks overlapping 1011
// patterns actually driven on the line, including across idle/gap zeros.
//
// Ports:
//   clk        in   single clock, all logic on posedge
//   rst        in   synchronous reset, active-high
//   din        in   [WIDTH-1:0] word to transmit
//   din_valid  in   din holds a word
//   din_ready  out  block can accept a word (registered)
//   a_out      out  serial line to the detector (registered)
//   a_valid    out  a_out carries a data bit (registered)
//   tx_done    out  one-cycle pulse on the last bit of a word (registered)
//   match_clr  in   clears match_cnt on the next cycle (wins over a match)
//   match_cnt  out  [CNT_W-1:0] saturating count of 1011 patterns on a_out
// -----------------------------------------------------------------------------
module phat_chuoi_1011 #(
  parameter int WIDTH      = 8,  // 4..32
  parameter int GAP_CYCLES = 2,  // 0..15
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             a_out,
  output logic             a_valid,
  output logic             tx_done,
  input  logic             match_clr,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int BIT_CNT_W = $clog2(WIDTH);
  localparam int GAP_CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_shift;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [GAP_CNT_W-1:0]   r_gap_cnt;
  logic                   r_a_out;
  logic                   r_a_valid;
  logic                   r_tx_done;
  logic                   r_din_ready;
  logic [2:0]             r_hist;
  logic [CNT_W-1:0]       r_match_cnt;

  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       w_shift_nxt;
  logic [BIT_CNT_W-1:0]   w_bit_cnt_nxt;
  logic [GAP_CNT_W-1:0]   w_gap_cnt_nxt;
  logic                   w_a_out_nxt;
  logic                   w_a_valid_nxt;
  logic                   w_tx_done_nxt;
  logic                   w_din_ready_nxt;
  logic                   w_match;

  // Next-state logic. Outputs are decoded from the *next* state so they can be
  // registered and still line up with the state they describe.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;

    unique case (r_state)
      IDLE: begin
        if (din_valid) begin
          w_state_nxt   = SHIFT;
          w_shift_nxt   = din;
          w_bit_cnt_nxt = BIT_CNT_W'(WIDTH - 1);
        end
      end
      SHIFT: begin
        w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
        if (r_bit_cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            w_state_nxt   = GAP;
            w_gap_cnt_nxt = GAP_CNT_W'(GAP_CYCLES - 1);
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_a_valid_nxt   = (w_state_nxt == SHIFT);
    w_a_out_nxt     = (w_state_nxt == SHIFT) && w_shift_nxt[WIDTH-1];
    w_tx_done_nxt   = (w_state_nxt == SHIFT) && (w_bit_cnt_nxt == '0);
    w_din_ready_nxt = (w_state_nxt == IDLE);
  end

  // The line history plus the current bit form the 4-bit window; idle and gap
  // zeros enter the history too, so matches only bridge words through them.
  assign w_match = ({r_hist, r_a_out} == 4'b1011);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_a_out     <= 1'b0;
      r_a_valid   <= 1'b0;
      r_tx_done   <= 1'b0;
      r_din_ready <= 1'b1;
      r_hist      <= 3'b000;
      r_match_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_a_out     <= w_a_out_nxt;
      r_a_valid   <= w_a_valid_nxt;
      r_tx_done   <= w_tx_done_nxt;
      r_din_ready <= w_din_ready_nxt;
      r_hist      <= {r_hist[1:0], r_a_out};
      // Clear has priority over a coincident match; the count never wraps.
      if (match_clr) begin
        r_match_cnt <= '0;
      end else if (w_match && (r_match_cnt != CNT_MAX)) begin
        r_match_cnt <= r_match_cnt + 1'b1;
      end
    end
  end

  assign din_ready = r_din_ready;
  assign a_out     = r_a_out;
  assign a_valid   = r_a_valid;
  assign tx_done   = r_tx_done;
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_phat_chuoi_1011.sv
// -----------------------------------------------------------------------------
// tb_phat_chuoi_1011 - directed bench for phat_chuoi_1011.
//
// Three instances: u_dut (defaults), u_dut_c2 (CNT_W=2, same inputs as u_dut,
// so only its counter differs) and u_dut_g0 (GAP_CYCLES=0, own inputs).
// Expected serial bits of u_dut are queued when a word is presented and
// popped by a negedge monitor whenever a_valid is high.
// -----------------------------------------------------------------------------
module tb_phat_chuoi_1011;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             match_clr;
  logic             din_ready, a_out, a_valid, tx_done;
  logic [7:0]       match_cnt;

  logic             din_ready_c2, a_out_c2, a_valid_c2, tx_done_c2;
  logic [1:0]       match_cnt_c2;

  logic [WIDTH-1:0] din_g0;
  logic             din_valid_g0;
  logic             match_clr_g0;
  logic             din_ready_g0, a_out_g0, a_valid_g0, tx_done_g0;
  logic [7:0]       match_cnt_g0;

  exp_t             q[$];
  exp_t             e;
  int               n_cmp;
  int               n_fail;

  phat_chuoi_1011 u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .a_out(a_out), .a_valid(a_valid),
    .tx_done(tx_done), .match_clr(match_clr), .match_cnt(match_cnt)
  );

  phat_chuoi_1011 #(.CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_c2), .a_out(a_out_c2), .a_valid(a_valid_c2),
    .tx_done(tx_done_c2), .match_clr(match_clr), .match_cnt(match_cnt_c2)
  );

  phat_chuoi_1011 #(.GAP_CYCLES(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .din(din_g0), .din_valid(din_valid_g0),
    .din_ready(din_ready_g0), .a_out(a_out_g0), .a_valid(a_valid_g0),
    .tx_done(tx_done_g0), .match_clr(match_clr_g0), .match_cnt(match_cnt_g0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      q.push_back(exp_t'{b: w[i], last: (i == 0)});
    end
  endtask

  // Presents w, waits (bounded) until the DUT is ready, lets the accept edge
  // pass and returns in the cycle carrying the first bit.
  task automatic send_word(input logic [WIDTH-1:0] w);
    int guard;
    guard = 0;
    din = w;
    din_valid = 1'b1;
    push_word(w);
    while (din_ready !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    check("accept_wait", 32'(din_ready), 32'd1);
    tick();
    din_valid = 1'b0;
  endtask

  // Scoreboard monitor: every valid bit must match the next queued bit.
  always @(negedge clk) begin
    if (a_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_bit", 32'(a_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check("a_out", 32'(a_out), 32'(e.b));
        check("tx_done", 32'(tx_done), 32'(e.last));
      end
    end else if (rst === 1'b0) begin
      check("tx_done_idle", 32'(tx_done), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    match_clr = 1'b0;
    din_g0 = '0;
    din_valid_g0 = 1'b0;
    match_clr_g0 = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_a_out", 32'(a_out), 32'd0);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_match_cnt", 32'(match_cnt), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd1);
    check("rst_din_ready_g0", 32'(din_ready_g0), 32'd1);

    // Reset held with din_valid high: nothing is accepted
    din = 8'hB6;
    din_valid = 1'b1;
    tick();
    check("rst_no_accept_valid", 32'(a_valid), 32'd0);
    check("rst_no_accept_ready", 32'(din_ready), 32'd1);
    din_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_a_valid", 32'(a_valid), 32'd0);

    // Single word with defaults, accepted at edge T
    din = 8'b10110110;
    din_valid = 1'b1;
    push_word(8'b10110110);
    tick();
    din_valid = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      check("ready_low_shift", 32'(din_ready), 32'd0);
      tick();
    end
    // cycle T+9
    check("t9_match_cnt", 32'(match_cnt), 32'd2);
    check("t9_match_cnt_c2", 32'(match_cnt_c2), 32'd2);
    check("t9_a_valid", 32'(a_valid), 32'd0);
    check("t9_din_ready", 32'(din_ready), 32'd0);
    match_clr = 1'b1;
    tick();
    match_clr = 1'b0;
    // cycle T+10
    check("t10_din_ready", 32'(din_ready), 32'd0);
    check("t10_clr", 32'(match_cnt), 32'd0);
    tick();
    // cycle T+11
    check("t11_din_ready", 32'(din_ready), 32'd1);

    // Back-to-back with din_valid held high: 0xB0 at edge T', then 0x0B
    din = 8'hB0;
    din_valid = 1'b1;
    push_word(8'hB0);
    tick();
    din = 8'h0B;
    push_word(8'h0B);
    repeat (8) tick();
    check("b2b_t9_a_valid", 32'(a_valid), 32'd0);
    check("b2b_t9_ready", 32'(din_ready), 32'd0);
    tick();
    check("b2b_t10_a_valid", 32'(a_valid), 32'd0);
    tick();
    check("b2b_t11_ready", 32'(din_ready), 32'd1);
    tick();
    check("b2b_t12_a_valid", 32'(a_valid), 32'd1);
    din_valid = 1'b0;
    repeat (8) tick();
    check("b2b_match_cnt", 32'(match_cnt), 32'd2);
    check("b2b_match_cnt_c2", 32'(match_cnt_c2), 32'd2);

    // No-match words: count unchanged
    send_word(8'hFF);
    repeat (9) tick();
    send_word(8'h00);
    repeat (9) tick();
    check("nomatch_cnt", 32'(match_cnt), 32'd2);

    // Reset in the middle of a word
    send_word(8'hB6);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    check("midrst_a_valid", 32'(a_valid), 32'd0);
    check("midrst_a_out", 32'(a_out), 32'd0);
    check("midrst_din_ready", 32'(din_ready), 32'd1);
    check("midrst_tx_done", 32'(tx_done), 32'd0);
    check("midrst_match_cnt", 32'(match_cnt), 32'd0);
    tick();
    check("midrst_no_resume", 32'(a_valid), 32'd0);
    send_word(8'hB6);
    repeat (9) tick();
    check("fresh_match_cnt", 32'(match_cnt), 32'd2);

    // Saturation with CNT_W=2, and clear behaviour
    match_clr = 1'b1;
    tick();
    match_clr = 1'b0;
    check("clr_main", 32'(match_cnt), 32'd0);
    check("clr_c2", 32'(match_cnt_c2), 32'd0);
    send_word(8'hB6);
    repeat (9) tick();
    check("sat_first_c2", 32'(match_cnt_c2), 32'd2);
    send_word(8'hB6);
    repeat (9) tick();
    check("sat_main", 32'(match_cnt), 32'd4);
    check("sat_c2", 32'(match_cnt_c2), 32'd3);
    repeat (5) tick();
    check("sat_hold_c2", 32'(match_cnt_c2), 32'd3);
    match_clr = 1'b1;
    tick();
    match_clr = 1'b0;
    check("sat_clr_c2", 32'(match_cnt_c2), 32'd0);

    // Clear coincident with a match (1011 complete on cycle T+4)
    send_word(8'hB6);
    repeat (3) tick();
    match_clr = 1'b1;
    tick();
    match_clr = 1'b0;
    check("clr_wins_main", 32'(match_cnt), 32'd0);
    check("clr_wins_c2", 32'(match_cnt_c2), 32'd0);
    repeat (5) tick();
    check("after_clr_main", 32'(match_cnt), 32'd1);
    check("after_clr_c2", 32'(match_cnt_c2), 32'd1);

    // GAP_CYCLES=0: the single idle zero between words breaks 101|1
    din_g0 = 8'b00000101;
    din_valid_g0 = 1'b1;
    check("g0_ready", 32'(din_ready_g0), 32'd1);
    tick();
    din_g0 = 8'b10000000;
    repeat (7) tick();
    check("g0_t8_tx_done", 32'(tx_done_g0), 32'd1);
    check("g0_t8_a_out", 32'(a_out_g0), 32'd1);
    tick();
    check("g0_t9_a_valid", 32'(a_valid_g0), 32'd0);
    check("g0_t9_ready", 32'(din_ready_g0), 32'd1);
    tick();
    check("g0_t10_a_valid", 32'(a_valid_g0), 32'd1);
    check("g0_t10_a_out", 32'(a_out_g0), 32'd1);
    din_valid_g0 = 1'b0;
    repeat (9) tick();
    check("g0_match_cnt", 32'(match_cnt_g0), 32'd0);

    repeat (4) tick();
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
